// File: rtl/led_pattern_seq.sv
// Button-driven LED pattern sequencer: a debounced push button cycles through four
// patterns (run, bounce, count, blink), and the upstream TICK enable steps each pattern.
module led_pattern_seq #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TICK,
  input  logic       BTN_N,
  output logic [7:0] LED,
  output logic [1:0] MODE
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  logic             btn_meta_q, btn_sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press;
  mode_e            mode_q, mode_d;
  dir_e             dir_q, dir_d;
  logic [7:0]       led_q, led_d;

  function automatic logic [7:0] mode_init(input mode_e m);
    case (m)
      MODE_RUN, MODE_BOUNCE: return 8'h01;
      default:               return 8'h00;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      btn_meta_q <= 1'b1;
      btn_sync_q <= 1'b1;
      stable_q   <= 1'b1;
      cnt_q      <= '0;
      mode_q     <= MODE_RUN;
      dir_q      <= DIR_LEFT;
      led_q      <= 8'h01;
    end else begin
      btn_meta_q <= BTN_N;
      btn_sync_q <= btn_meta_q;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      dir_q      <= dir_d;
      led_q      <= led_d;
    end
  end

  // Debounce: any cycle where the synchronized level matches the stable one restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (btn_sync_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = btn_sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Press event is high during the single cycle in which stable is about to fall.
  assign press = stable_q & ~stable_d;

  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    led_d  = led_q;
    if (press) begin
      mode_d = mode_e'(mode_q + 2'd1);
      dir_d  = DIR_LEFT;
      led_d  = mode_init(mode_d);
    end else if (TICK) begin
      case (mode_q)
        MODE_RUN: led_d = {led_q[6:0], led_q[7]};
        MODE_BOUNCE: begin
          if (dir_q == DIR_LEFT) begin
            if (led_q == 8'h80) begin
              led_d = 8'h40;
              dir_d = DIR_RIGHT;
            end else begin
              led_d = {led_q[6:0], 1'b0};
            end
          end else begin
            if (led_q == 8'h01) begin
              led_d = 8'h02;
              dir_d = DIR_LEFT;
            end else begin
              led_d = {1'b0, led_q[7:1]};
            end
          end
        end
        MODE_COUNT: led_d = led_q + 8'd1;
        default:    led_d = ~led_q;
      endcase
    end
  end

  assign LED  = led_q;
  assign MODE = mode_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq with a short debounce window; inputs change on
// the falling edge and outputs are checked there too.
module tb_led_pattern_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       btn_n;
  logic [7:0] led;
  logic [1:0] mode;

  int n_assert = 0;
  int n_fail   = 0;

  led_pattern_seq #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK  (clk),
    .RESET(reset),
    .TICK (tick),
    .BTN_N(btn_n),
    .LED  (led),
    .MODE (mode)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: bench still running, observed no end, expected end before 200us");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  // Clean press and release, each held well past the debounce window.
  task automatic press_release();
    btn_n = 1'b0;
    cycles(10);
    btn_n = 1'b1;
    cycles(10);
  endtask

  logic [7:0] exp_run [9]    = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
  logic [7:0] exp_bounce [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                  8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  initial begin
    reset = 1'b1;
    tick  = 1'b0;
    btn_n = 1'b1;
    cycles(3);
    reset = 1'b0;
    check("reset_led", led, 8'h01);
    check("reset_mode", {6'b0, mode}, 8'h00);

    // Mode 0 rotate-left.
    for (int i = 0; i < 9; i++) begin
      do_tick();
      check($sformatf("run_step%0d", i), led, exp_run[i]);
    end
    check("run_mode", {6'b0, mode}, 8'h00);
    cycles(3);
    check("run_idle_hold", led, 8'h02);

    // Short lows and single-cycle bounces must never be accepted.
    for (int r = 0; r < 3; r++) begin
      btn_n = 1'b0; cycles(3);
      btn_n = 1'b1; cycles(2);
      btn_n = 1'b0; cycles(1);
      btn_n = 1'b1; cycles(1);
      btn_n = 1'b0; cycles(1);
      btn_n = 1'b1; cycles(2);
    end
    cycles(4);
    check("bounce_mode", {6'b0, mode}, 8'h00);
    check("bounce_led", led, 8'h02);

    // Long press: exactly one mode step, release adds nothing.
    btn_n = 1'b0;
    cycles(10);
    check("press_mode", {6'b0, mode}, 8'h01);
    check("press_led", led, 8'h01);
    btn_n = 1'b1;
    cycles(10);
    check("release_mode", {6'b0, mode}, 8'h01);
    check("release_led", led, 8'h01);

    // Mode 1 bounce pattern, full 14-step period plus one.
    for (int i = 0; i < 15; i++) begin
      do_tick();
      check($sformatf("bounce_step%0d", i), led, exp_bounce[i]);
    end
    check("bounce_pat_mode", {6'b0, mode}, 8'h01);

    // Mode 2 counter; TICK held high for 254 cycles gives 254 steps.
    press_release();
    check("count_mode", {6'b0, mode}, 8'h02);
    check("count_init", led, 8'h00);
    tick = 1'b1;
    cycles(254);
    tick = 1'b0;
    check("count_fe", led, 8'hFE);
    do_tick();
    check("count_ff", led, 8'hFF);
    do_tick();
    check("count_wrap", led, 8'h00);

    // Mode 3 blink, then wrap back to mode 0.
    press_release();
    check("blink_mode", {6'b0, mode}, 8'h03);
    check("blink_init", led, 8'h00);
    do_tick();
    check("blink_on", led, 8'hFF);
    do_tick();
    check("blink_off", led, 8'h00);
    press_release();
    check("wrap_mode", {6'b0, mode}, 8'h00);
    check("wrap_led", led, 8'h01);

    // Press and TICK on the same edge: press wins.
    do_tick();
    check("pre_coinc_led", led, 8'h02);
    btn_n = 1'b0;
    cycles(5);
    check("pre_coinc_mode", {6'b0, mode}, 8'h00);
    do_tick();
    check("coinc_mode", {6'b0, mode}, 8'h01);
    check("coinc_led", led, 8'h01);
    cycles(1);
    check("coinc_led_hold", led, 8'h01);
    btn_n = 1'b1;
    cycles(10);
    check("coinc_release_mode", {6'b0, mode}, 8'h01);

    // Reset mid-pattern and mid-debounce, with TICK asserted alongside.
    do_tick(); do_tick(); do_tick();
    check("mid_pattern_led", led, 8'h08);
    btn_n = 1'b0;
    cycles(3);
    reset = 1'b1;
    tick  = 1'b1;
    cycles(1);
    reset = 1'b0;
    tick  = 1'b0;
    btn_n = 1'b1;
    check("rst_mid_led", led, 8'h01);
    check("rst_mid_mode", {6'b0, mode}, 8'h00);
    cycles(10);
    check("rst_mid_after_mode", {6'b0, mode}, 8'h00);

    // Reset while button is held after acceptance; releasing afterwards is no event.
    btn_n = 1'b0;
    cycles(8);
    check("held_mode", {6'b0, mode}, 8'h01);
    btn_n = 1'b1; cycles(1);
    btn_n = 1'b0; cycles(1);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    btn_n = 1'b1;
    check("rst_held_mode", {6'b0, mode}, 8'h00);
    check("rst_held_led", led, 8'h01);
    cycles(10);
    check("rst_release_mode", {6'b0, mode}, 8'h00);
    check("rst_release_led", led, 8'h01);

    do_tick();
    check("first_tick_after_reset", led, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
